multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I datapath: PC register, instruction memory, register file, ALU, sign-extend and next-PC mux.
- Replaces the single-cycle control unit.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with variable-latency instruction and data memories.
- Counts retired instructions; traps on illegal opcodes or memory timeouts.

---
 rtl/cpu_ctrl_pkg.sv | 56 +++++
 rtl/multicycle_ctrl_instr_decoder.sv | 45 ++++
 rtl/multicycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Covers sequencer states, the supported opcode fields, datapath select codes and trap causes.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      TRAP
   } state_t;

   localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
   localparam logic [6:0] OP_ALU_REG = 7'b0110011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10
   } imm_src_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ILLEGAL = 2'b01,
      CAUSE_TIMEOUT = 2'b10
   } trap_cause_t;

   typedef enum logic [2:0] {
      CLS_ADDI,
      CLS_ADD,
      CLS_SUB,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_BNE,
      CLS_ILLEGAL
   } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_instr_decoder.sv
// Combinational classifier for the RV32I subset the sequencer supports.
// Any opcode/funct3/funct7 pattern outside that subset is reported as illegal.
module instr_decoder
   import cpu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] instr,
   output instr_class_t          cls,
   output logic                  illegal,
   output logic                  rd_is_zero
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_reg_fields;

   assign opcode            = instr[6:0];
   assign funct3            = instr[14:12];
   assign funct7            = instr[31:25];
   assign unused_reg_fields = ^instr[24:15];

   always_comb begin
      cls = CLS_ILLEGAL;
      case (opcode)
         OP_ALU_IMM: if (funct3 == F3_ADD) cls = CLS_ADDI;
         OP_ALU_REG: begin
            if (funct3 == F3_ADD && funct7 == F7_ADD)      cls = CLS_ADD;
            else if (funct3 == F3_ADD && funct7 == F7_SUB) cls = CLS_SUB;
         end
         OP_LOAD:    if (funct3 == F3_WORD) cls = CLS_LW;
         OP_STORE:   if (funct3 == F3_WORD) cls = CLS_SW;
         OP_BRANCH: begin
            if (funct3 == F3_BEQ)      cls = CLS_BEQ;
            else if (funct3 == F3_BNE) cls = CLS_BNE;
         end
         default: ;
      endcase
   end

   assign illegal    = (cls == CLS_ILLEGAL);
   assign rd_is_zero = (instr[11:7] == 5'd0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, a retired-instruction counter and a sticky trap on illegal opcodes or timeouts.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  eq,
   input  logic                  imem_ready,
   input  logic                  dmem_ready,
   output logic                  imem_req,
   output logic                  ir_we,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic                  reg_write,
   output logic                  alu_src,
   output logic [2:0]            alu_ctrl,
   output logic [1:0]            imm_src,
   output logic                  result_src,
   output logic                  pc_we,
   output logic                  pc_src,
   output logic                  trap,
   output logic [1:0]            trap_cause,
   output logic [CNT_WIDTH-1:0]  retired
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

   state_t               state;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [CNT_WIDTH-1:0] retired_q;
   logic [1:0]           cause_q;

   instr_class_t cls;
   logic         illegal;
   logic         rd_is_zero;

   instr_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_decoder (
      .instr      (instr),
      .cls        (cls),
      .illegal    (illegal),
      .rd_is_zero (rd_is_zero)
   );

   logic      is_branch, is_load, is_store, taken, retire, timeout;
   logic      alu_src_sel;
   alu_ctrl_t alu_ctrl_sel;
   imm_src_t  imm_sel;

   always_comb begin
      is_branch    = (cls == CLS_BEQ) || (cls == CLS_BNE);
      is_load      = (cls == CLS_LW);
      is_store     = (cls == CLS_SW);
      taken        = ((cls == CLS_BEQ) && eq) || ((cls == CLS_BNE) && !eq);
      alu_src_sel  = (cls == CLS_ADDI) || is_load || is_store;
      alu_ctrl_sel = ((cls == CLS_SUB) || is_branch) ? ALU_SUB : ALU_ADD;
      imm_sel      = is_store ? IMM_S : (is_branch ? IMM_B : IMM_I);
      retire       = ((state == EXEC) && is_branch) ||
                     ((state == MEM) && dmem_ready && is_store) ||
                     (state == WB);
      timeout      = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT) &&
                     (((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready));
   end

   // A ready arriving in the limit cycle is checked first, so it always beats the timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= FETCH;
         wait_cnt  <= '0;
         retired_q <= '0;
         cause_q   <= CAUSE_NONE;
      end else begin
         if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
         case (state)
            FETCH: begin
               if (imem_ready) state <= DECODE;
               else if (timeout) begin
                  state   <= TRAP;
                  cause_q <= CAUSE_TIMEOUT;
               end else wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            DECODE: begin
               if (illegal) begin
                  state   <= TRAP;
                  cause_q <= CAUSE_ILLEGAL;
               end else state <= EXEC;
            end
            EXEC: begin
               wait_cnt <= '0;
               if (is_branch) state <= FETCH;
               else if (is_load || is_store) state <= MEM;
               else state <= WB;
            end
            MEM: begin
               if (dmem_ready) begin
                  wait_cnt <= '0;
                  state    <= is_store ? FETCH : WB;
               end else if (timeout) begin
                  state   <= TRAP;
                  cause_q <= CAUSE_TIMEOUT;
               end else wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            WB: begin
               wait_cnt <= '0;
               state    <= FETCH;
            end
            default: state <= TRAP;
         endcase
      end
   end

   // There is no ALU output register, so the operand selects stay driven through MEM and WB.
   always_comb begin
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      alu_ctrl   = ALU_ADD;
      imm_src    = IMM_I;
      result_src = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      trap       = 1'b0;
      if (rst) begin
         case (state)
            FETCH: begin
               imem_req = 1'b1;
               ir_we    = imem_ready;
            end
            DECODE: imm_src = imm_sel;
            EXEC: begin
               alu_src  = alu_src_sel;
               alu_ctrl = alu_ctrl_sel;
               imm_src  = imm_sel;
               pc_we    = is_branch;
               pc_src   = is_branch && taken;
            end
            MEM: begin
               alu_src  = alu_src_sel;
               alu_ctrl = alu_ctrl_sel;
               imm_src  = imm_sel;
               dmem_req = 1'b1;
               dmem_we  = is_store;
               pc_we    = dmem_ready && is_store;
            end
            WB: begin
               alu_src    = alu_src_sel;
               alu_ctrl   = alu_ctrl_sel;
               imm_src    = imm_sel;
               reg_write  = !rd_is_zero;
               result_src = is_load;
               pc_we      = 1'b1;
            end
            TRAP: trap = 1'b1;
            default: ;
         endcase
      end
   end

   assign trap_cause = cause_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by random instruction
// streams, each checked cycle by cycle against a per-instruction timeline model.
module tb_multicycle_ctrl;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 16;

   localparam int K_ADDI = 0;
   localparam int K_ADD  = 1;
   localparam int K_SUB  = 2;
   localparam int K_LW   = 3;
   localparam int K_SW   = 4;
   localparam int K_BEQ  = 5;
   localparam int K_BNE  = 6;
   localparam int K_ILL  = 7;

   typedef struct packed {
      logic       imem_req;
      logic       ir_we;
      logic       dmem_req;
      logic       dmem_we;
      logic       reg_write;
      logic       alu_src;
      logic [2:0] alu_ctrl;
      logic [1:0] imm_src;
      logic       result_src;
      logic       pc_we;
      logic       pc_src;
      logic       trap;
      logic [1:0] trap_cause;
   } ctl_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      instr;
   logic             eq;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_req, ir_we, dmem_req, dmem_we, reg_write, alu_src;
   logic [2:0]       alu_ctrl;
   logic [1:0]       imm_src;
   logic             result_src, pc_we, pc_src, trap;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] retired;
   ctl_t             act;

   int checks;
   int errors;
   int exp_retired;

   multicycle_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr      (instr),
      .eq         (eq),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .ir_we      (ir_we),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .reg_write  (reg_write),
      .alu_src    (alu_src),
      .alu_ctrl   (alu_ctrl),
      .imm_src    (imm_src),
      .result_src (result_src),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .trap       (trap),
      .trap_cause (trap_cause),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   assign act = {imem_req, ir_we, dmem_req, dmem_we, reg_write, alu_src, alu_ctrl,
                 imm_src, result_src, pc_we, pc_src, trap, trap_cause};

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] ins, input logic eq_v, input logic ir, input logic dr);
      instr      = ins;
      eq         = eq_v;
      imem_ready = ir;
      dmem_ready = dr;
   endtask

   // Called at a negedge with inputs applied; checks before the next rising edge.
   task automatic checkCycle(input string tag, input ctl_t e, input bit retires);
      #2;
      checkOutput(tag, 32'(act), 32'(e));
      checkOutput({tag, "_retired"}, 32'(retired), 32'(exp_retired));
      if (retires) exp_retired = (exp_retired + 1) % (1 << CNT_W);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b0;
      applyStimulus(32'($urandom), 1'($urandom), 1'b1, 1'b1);
      exp_retired = 0;
      #2;
      checkOutput("reset_outputs", 32'(act), 32'd0);
      checkOutput("reset_retired", 32'(retired), 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic checkTrap(input logic [1:0] cause);
      ctl_t e;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(32'($urandom), 1'($urandom), 1'b1, 1'b1);
         e = '0;
         e.trap = 1'b1;
         e.trap_cause = cause;
         checkCycle("trap", e, 1'b0);
      end
      doReset();
   endtask

   function automatic ctl_t kindCtl(input int kind);
      ctl_t c;
      c = '0;
      c.alu_src  = (kind == K_ADDI) || (kind == K_LW) || (kind == K_SW);
      c.alu_ctrl = ((kind == K_SUB) || (kind == K_BEQ) || (kind == K_BNE)) ? 3'b001 : 3'b000;
      c.imm_src  = (kind == K_SW) ? 2'b01 : (((kind == K_BEQ) || (kind == K_BNE)) ? 2'b10 : 2'b00);
      return c;
   endfunction

   task automatic genInstr(input int kind, output logic [31:0] ins, output logic rd_zero);
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] imm;
      rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs1     = 5'($urandom);
      rs2     = 5'($urandom);
      imm     = 12'($urandom);
      rd_zero = (rd == 5'd0);
      case (kind)
         K_ADDI:  ins = {imm, rs1, 3'b000, rd, 7'b0010011};
         K_ADD:   ins = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
         K_SUB:   ins = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
         K_LW:    ins = {imm, rs1, 3'b010, rd, 7'b0000011};
         K_SW:    ins = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
         K_BEQ:   ins = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
         K_BNE:   ins = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100011};
         default: begin
            case ($urandom_range(0, 5))
               0:       ins = 32'h0000_0000;
               1:       ins = {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
               2:       ins = {imm, rs1, 3'b000, rd, 7'b0000011};
               3:       ins = {imm[11:5], rs2, rs1, 3'b100, imm[4:0], 7'b1100011};
               4:       ins = {imm, rs1, 3'b001, rd, 7'b0010011};
               default: ins = {imm, rs1, 3'b000, rd, 7'b0110111};
            endcase
         end
      endcase
   endtask

   // Walks one instruction through its expected timeline; l1/l2 are not-ready cycles before ready.
   task automatic runInstr(input logic [31:0] ins, input int kind, input logic eq_v, input logic rd_zero,
                           input int l1, input int l2, input int abort_at);
      ctl_t e, ctl;
      bit   is_br, is_mem, is_sw;
      ctl    = kindCtl(kind);
      is_br  = (kind == K_BEQ) || (kind == K_BNE);
      is_mem = (kind == K_LW) || (kind == K_SW);
      is_sw  = (kind == K_SW);
      for (int i = 0; i < l1 && i < TIMEOUT; i++) begin
         applyStimulus(ins, 1'b0, 1'b0, 1'b0);
         e = '0;
         e.imem_req = 1'b1;
         checkCycle("fetch_wait", e, 1'b0);
      end
      if (l1 >= TIMEOUT) begin
         checkTrap(2'b10);
         return;
      end
      applyStimulus(ins, 1'b0, 1'b1, 1'b0);
      e = '0;
      e.imem_req = 1'b1;
      e.ir_we = 1'b1;
      checkCycle("fetch", e, 1'b0);
      applyStimulus(ins, 1'b0, 1'b0, 1'b0);
      e = '0;
      e.imm_src = ctl.imm_src;
      checkCycle("decode", e, 1'b0);
      if (kind == K_ILL) begin
         checkTrap(2'b01);
         return;
      end
      applyStimulus(ins, eq_v, 1'b0, 1'b0);
      e = ctl;
      if (is_br) begin
         e.pc_we  = 1'b1;
         e.pc_src = (kind == K_BEQ) ? eq_v : !eq_v;
      end
      checkCycle("exec", e, is_br);
      if (is_br) return;
      if (is_mem) begin
         for (int i = 0; i < l2 && i < TIMEOUT; i++) begin
            if (i == abort_at) return;
            applyStimulus(ins, 1'($urandom), 1'b0, 1'b0);
            e = ctl;
            e.dmem_req = 1'b1;
            e.dmem_we  = is_sw;
            checkCycle("mem_wait", e, 1'b0);
         end
         if (l2 >= TIMEOUT) begin
            checkTrap(2'b10);
            return;
         end
         applyStimulus(ins, 1'b0, 1'b0, 1'b1);
         e = ctl;
         e.dmem_req = 1'b1;
         e.dmem_we  = is_sw;
         e.pc_we    = is_sw;
         checkCycle("mem", e, is_sw);
         if (is_sw) return;
      end
      applyStimulus(ins, 1'b0, 1'b0, 1'b0);
      e = ctl;
      e.reg_write  = !rd_zero;
      e.result_src = (kind == K_LW);
      e.pc_we      = 1'b1;
      checkCycle("wb", e, 1'b1);
   endtask

   function automatic int pickLatency();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return TIMEOUT;
      if (r == 1) return TIMEOUT - 1;
      return $urandom_range(0, 3);
   endfunction

   initial begin
      logic [31:0] ins;
      logic        rdz;
      int          kind;
      checks      = 0;
      errors      = 0;
      exp_retired = 0;
      rst         = 1'b0;
      applyStimulus(32'd0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      doReset();

      runInstr(32'h0050_0093, K_ADDI, 1'b0, 1'b0, 0, 0, -1);
      runInstr(32'hFE20_9EE3, K_BNE, 1'b0, 1'b0, 0, 0, -1);
      runInstr(32'hFE20_9EE3, K_BNE, 1'b1, 1'b0, 0, 0, -1);
      runInstr(32'h0000_A183, K_LW, 1'b0, 1'b0, 0, 3, -1);
      runInstr(32'h0010_0013, K_ADDI, 1'b0, 1'b1, 0, 0, -1);
      runInstr(32'h0050_0093, K_ADDI, 1'b0, 1'b0, TIMEOUT, 0, -1);
      runInstr(32'h0050_0093, K_ADDI, 1'b0, 1'b0, TIMEOUT - 1, 0, -1);
      runInstr(32'h0000_A183, K_LW, 1'b0, 1'b0, 0, TIMEOUT - 1, -1);
      runInstr(32'h0000_0000, K_ILL, 1'b0, 1'b0, 0, 0, -1);
      runInstr(32'h0020_A223, K_SW, 1'b0, 1'b0, 0, 0, -1);
      runInstr(32'h0020_A223, K_SW, 1'b0, 1'b0, 0, TIMEOUT, -1);
      runInstr(32'h0020_A223, K_SW, 1'b0, 1'b0, 1, 20, 2);
      doReset();

      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 11);
         if (kind == 11) kind = K_ILL;
         else if (kind > 6) kind = kind - 7;
         genInstr(kind, ins, rdz);
         runInstr(ins, kind, 1'($urandom), rdz, pickLatency(), pickLatency(), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
